// File: rtl/regfile_sync_bypass_if.sv
// Register file bus: decode-side read addresses, writeback-side write port and status.
// Used by regfile_sync_bypass (optional REGFILE_ZERO_REG_EN lives in the design file).
interface regfile_sync_bypass_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  clear_req;
  logic [ADDR_WIDTH-1:0] read_address_0;
  logic [ADDR_WIDTH-1:0] read_address_1;
  logic [ADDR_WIDTH-1:0] write_address_0;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data_0;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  busy;
  logic                  write_dropped;

  modport master (
    output clear_req,
    output read_address_0,
    output read_address_1,
    output write_address_0,
    output write_en,
    output write_data,
    input  read_data_0,
    input  read_data_1,
    input  busy,
    input  write_dropped
  );

  modport slave (
    input  clear_req,
    input  read_address_0,
    input  read_address_1,
    input  write_address_0,
    input  write_en,
    input  write_data,
    output read_data_0,
    output read_data_1,
    output busy,
    output write_dropped
  );
endinterface

// File: rtl/regfile_sync_bypass.sv
// Two-read/one-write register file with write-to-read bypass and a hardware clear sweep.
// Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_sync_bypass #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  regfile_sync_bypass_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  write_dropped_q, write_dropped_d;
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  logic                  ready;
  logic                  wr_zero;
  logic                  wr_fire;
  logic                  rd0_zero, rd1_zero;
  logic                  byp_0, byp_1;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign ready = (state_q == StReady);

`ifdef REGFILE_ZERO_REG_EN
  assign wr_zero  = (bus.write_address_0 == '0);
  assign rd0_zero = (bus.read_address_0 == '0);
  assign rd1_zero = (bus.read_address_1 == '0);
`else
  assign wr_zero  = 1'b0;
  assign rd0_zero = 1'b0;
  assign rd1_zero = 1'b0;
`endif

  // A write lands only in READY with no competing clear; entry-0 writes vanish quietly.
  assign wr_fire = ready && bus.write_en && !bus.clear_req && !wr_zero;

  assign byp_0 = wr_fire && (bus.write_address_0 == bus.read_address_0);
  assign byp_1 = wr_fire && (bus.write_address_0 == bus.read_address_1);

  // Writes lost to a running or freshly requested clear are flagged, entry-0 writes are not.
  assign write_dropped_d = bus.write_en && !wr_zero && (!ready || bus.clear_req);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = 1'b0;
    ram_waddr = bus.write_address_0;
    ram_wdata = bus.write_data;
    case (state_q)
      StClear: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastAddr) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (bus.clear_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end else if (wr_fire) begin
          ram_we = 1'b1;
        end
      end
      default: begin
        state_d   = StClear;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StClear;
      clr_cnt_q       <= '0;
      write_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      write_dropped_q <= write_dropped_d;
    end
  end

  // Storage has no reset of its own; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  always_comb begin
    bus.read_data_0 = '0;
    bus.read_data_1 = '0;
    if (ready) begin
      if (rd0_zero) begin
        bus.read_data_0 = '0;
      end else if (byp_0) begin
        bus.read_data_0 = bus.write_data;
      end else begin
        bus.read_data_0 = ram_q[bus.read_address_0];
      end
      if (rd1_zero) begin
        bus.read_data_1 = '0;
      end else if (byp_1) begin
        bus.read_data_1 = bus.write_data;
      end else begin
        bus.read_data_1 = ram_q[bus.read_address_1];
      end
    end
  end

  assign bus.busy          = (state_q == StClear);
  assign bus.write_dropped = write_dropped_q;

endmodule

// File: tb/tb_regfile_sync_bypass.sv
// Directed bench for regfile_sync_bypass: sweep timing, readback, bypass, drops, clear and reset.
module tb_regfile_sync_bypass;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;

  regfile_sync_bypass_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_sync_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear_req       = 1'b0;
    bus.write_en        = 1'b0;
    bus.write_address_0 = '0;
    bus.write_data      = '0;
  endtask

  // Counts cycles that busy stays high, starting from the current sample.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    bus.read_address_0 = '0;
    bus.read_address_1 = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_rd0", bus.read_data_0, 32'h0);
    chk("rst_rd1", bus.read_data_1, 32'h0);
    chk("rst_wdrop", {31'd0, bus.write_dropped}, 32'd0);

    count_busy(n);
    chk("sweep_len", n, 32);
    chk("sweep_done", {31'd0, bus.busy}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus.read_address_0 = 5'(a);
      bus.read_address_1 = 5'(31 - a);
      #1;
      chk("swept_rd0", bus.read_data_0, 32'h0);
      chk("swept_rd1", bus.read_data_1, 32'h0);
    end

    // Plain write and readback
    bus.write_en = 1'b1; bus.write_address_0 = 5'd7; bus.write_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    bus.read_address_0 = 5'd7; bus.read_address_1 = 5'd8;
    #1;
    chk("wr7_rd", bus.read_data_0, 32'hDEADBEEF);
    chk("addr8_rd", bus.read_data_1, 32'h0);
    chk("wr7_nodrop", {31'd0, bus.write_dropped}, 32'd0);

    // Bypass on both ports
    bus.write_en = 1'b1; bus.write_address_0 = 5'd3; bus.write_data = 32'h12345678;
    bus.read_address_0 = 5'd3; bus.read_address_1 = 5'd3;
    #1;
    chk("byp_rd0", bus.read_data_0, 32'h12345678);
    chk("byp_rd1", bus.read_data_1, 32'h12345678);
    step();
    idle_inputs();
    #1;
    chk("byp_held0", bus.read_data_0, 32'h12345678);
    chk("byp_held1", bus.read_data_1, 32'h12345678);

    // Bypass on one port only
    bus.write_en = 1'b1; bus.write_address_0 = 5'd3; bus.write_data = 32'hCAFEF00D;
    bus.read_address_0 = 5'd3; bus.read_address_1 = 5'd7;
    #1;
    chk("byp1_rd0", bus.read_data_0, 32'hCAFEF00D);
    chk("byp1_rd1", bus.read_data_1, 32'hDEADBEEF);
    step();
    idle_inputs();

`ifdef REGFILE_ZERO_REG_EN
    bus.write_en = 1'b1; bus.write_address_0 = 5'd0; bus.write_data = 32'h0000AAAA;
    bus.read_address_0 = 5'd0;
    #1;
    chk("z0_nobyp", bus.read_data_0, 32'h0);
    step();
    idle_inputs();
    #1;
    chk("z0_rd", bus.read_data_0, 32'h0);
    chk("z0_nodrop", {31'd0, bus.write_dropped}, 32'd0);
`else
    bus.write_en = 1'b1; bus.write_address_0 = 5'd0; bus.write_data = 32'h0000AAAA;
    bus.read_address_0 = 5'd0;
    #1;
    chk("r0_byp", bus.read_data_0, 32'h0000AAAA);
    step();
    idle_inputs();
    #1;
    chk("r0_rd", bus.read_data_0, 32'h0000AAAA);
    chk("r0_nodrop", {31'd0, bus.write_dropped}, 32'd0);
`endif

    // clear_req with a simultaneous write: clear wins, no bypass
    bus.clear_req = 1'b1;
    bus.write_en = 1'b1; bus.write_address_0 = 5'd9; bus.write_data = 32'h00000099;
    bus.read_address_0 = 5'd9; bus.read_address_1 = 5'd7;
    #1;
    chk("clr_nobyp", bus.read_data_0, 32'h0);
    chk("clr_rd7", bus.read_data_1, 32'hDEADBEEF);
    step();
    idle_inputs();
    #1;
    chk("clr_busy", {31'd0, bus.busy}, 32'd1);
    chk("clr_wdrop", {31'd0, bus.write_dropped}, 32'd1);
    chk("clr_forced0", bus.read_data_1, 32'h0);

    // Write during the sweep is dropped; a repeated clear_req must not restart it
    bus.clear_req = 1'b1;
    bus.write_en = 1'b1; bus.write_address_0 = 5'd5; bus.write_data = 32'h000000FF;
    step();
    idle_inputs();
    #1;
    chk("busy_wdrop", {31'd0, bus.write_dropped}, 32'd1);
    step();
    chk("wdrop_clear", {31'd0, bus.write_dropped}, 32'd0);
    count_busy(n);
    chk("clr_rest_len", n, 30);
    for (int a = 0; a < 32; a++) begin
      bus.read_address_0 = 5'(a);
      #1;
      chk("clr_swept", bus.read_data_0, 32'h0);
    end

    // Reset in the middle of a sweep restarts it and wins over a pending write
    bus.write_en = 1'b1; bus.write_address_0 = 5'd12; bus.write_data = 32'h0BADC0DE;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    bus.write_en = 1'b1; bus.write_address_0 = 5'd4; bus.write_data = 32'h1;
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_wdrop", {31'd0, bus.write_dropped}, 32'd0);
    count_busy(n);
    chk("midrst_len", n, 32);
    bus.read_address_0 = 5'd12; bus.read_address_1 = 5'd7;
    #1;
    chk("midrst_rd12", bus.read_data_0, 32'h0);
    chk("midrst_rd7", bus.read_data_1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
